pat_seq_ctrl: RTL and testbench
===============================

Name: pat_seq_ctrl

Overview:
- Session controller for a serial pattern detector with a programmable pattern.
- Software arms a detection session with pattern, length, match target and bit budget. The block then consumes the gated serial stream (din/valid_i), flags every match (overlapping allowed) and counts matches and bits.
- It ends the session on target reached, budget exhausted or abort, and reports a status code.
- Sits between the config/control logic and the serial receive path.

Parameters:
- PAT_W, 8: maximum pattern length in bits.
- LEN_W, 4: width of cfg_len_i; must hold the value PAT_W.
- CNT_W, 8: width of the match counter and target.
- BUD_W, 16: width of the bit counter and budget.

Ports:
- clk_i in 1: clock, rising edge.
- rst_i in 1: reset, asynchronous, active-high.
- start_i in 1: session start request, sampled per cycle.
- abort_i in 1: terminate the running session.
- cfg_pat_i in PAT_W: pattern. Bit [len-1] is received first, bit 0 last.
- cfg_len_i in LEN_W: pattern length. Legal range 1..PAT_W.
- cfg_target_i in CNT_W: matches required. 0 means no target.
- cfg_budget_i in BUD_W: maximum accepted bits. 0 means unlimited.
- din in 1: serial data bit.
- valid_i in 1: din qualifier.
- busy_o out 1: session armed or running.
- done_o out 1: one-cycle pulse at session end.
- err_o out 1: one-cycle pulse when a start is rejected.
- pat_det_o out 1: one-cycle pulse per match.
- match_cnt_o out CNT_W: matches in the current or last session.
- bit_cnt_o out BUD_W: bits accepted in the current or last session.
- status_o out 2: 00 none/running, 01 target, 10 budget, 11 abort.

Behaviour:
- Reset (async assert, sync release):
  - State goes to IDLE.
  - All outputs 0; history, fill, counters and config registers cleared.
  - Reset mid-session discards the session; no done_o is issued.
- States: IDLE, ARM, RUN, DONE. All outputs are registered.
- IDLE:
  - start_i=1 with 1<=cfg_len_i<=PAT_W: latch pat, len, target and budget; go to ARM.
  - start_i=1 with an illegal len: err_o=1 for one cycle; remain in IDLE.
- ARM (1 cycle):
  - Clear history, fill count, match_cnt_o, bit_cnt_o and status_o; go to RUN.
  - busy_o=1 in ARM and RUN.
- RUN, on each cycle with valid_i=1:
  - Shift din into history at bit 0.
  - Increment fill, saturating at PAT_W.
  - Increment bit_cnt, saturating at all-ones.
  - Match when fill (after shift) >= len and history[len-1:0] == pat[len-1:0].
  - On match: pat_det_o=1 on the following cycle; match_cnt increments, saturating at all-ones.
  - History is not cleared on a match, so overlapping matches count.
- RUN, on cycles with valid_i=0: no state change; din is ignored.
- Termination, checked on the accepted bit, in priority order:
  - abort_i=1: status 11. Any bit in the same cycle is ignored, not counted and not matched. Abort needs no valid_i.
  - New match_cnt == target, with target != 0: status 01.
  - New bit_cnt == budget, with budget != 0: status 10.
  - Target and budget on the same bit: status 01.
- Terminating edge:
  - The state enters DONE.
  - done_o=1 for one cycle; busy_o=0.
  - A final match pulse on pat_det_o coincides with done_o.
- DONE (1 cycle): go to IDLE. match_cnt_o, bit_cnt_o and status_o hold until the next accepted start reaches ARM.
- Other start rules:
  - start_i during ARM, RUN or DONE is ignored; no err_o.
  - cfg_* inputs are don't-care except in the cycle a start is accepted.
  - abort_i outside RUN is ignored.
- Latency:
  - Start sampled at edge k: ARM after k; first bit can be accepted at edge k+2.
  - Match bit sampled at edge t: pat_det_o high during cycle t..t+1.

Optional Feature:
- Macro: PAT_SEQ_MASK_EN.
- When defined:
  - Adds input port cfg_mask_i [PAT_W], latched with the other config at start.
  - Mask bits set to 1 are don't-care in the compare: match when ((history ^ pat) & ~mask) over [len-1:0] is zero.
  - A start with all bits in [len-1:0] masked is rejected with err_o.
- When undefined: the port is absent and the compare is exact.

Test Plan:
- Overlapping matches: pat=4'b1101, len=4, target=2, budget=0; stream 1,1,0,1,1,0,1 with continuous valid -> pat_det_o pulses after bits 4 and 7; done_o with bit 7; status=01, match_cnt=2, bit_cnt=7.
- Budget exhaustion: pat=4'b1111, len=4, target=1, budget=5; stream 1,0,1,1,1 -> no pat_det_o; done_o after bit 5; status=10, bit_cnt=5, match_cnt=0.
- Valid gaps: repeat the first scenario with valid_i low 2 cycles between bits and din toggling in the gaps -> identical counts and status; pulses track the accepted bits.
- Simultaneous end: pat=1, len=1, target=3, budget=3; stream 1,1,1 -> status=01, match_cnt=3, three pulses, the last coincident with done_o.
- Control errors:
  - abort_i after 3 accepted bits -> done_o next cycle, status=11, bit_cnt=3.
  - start with len=0 -> err_o pulse, busy_o stays 0.
  - start while busy -> ignored.
- Async reset: assert rst_i mid-RUN between clock edges -> busy_o, counters and status clear immediately, no done_o; a new start runs the first scenario correctly.

Source files
------------

// File: rtl/pat_seq_ctrl.sv
// pat_seq_ctrl: session controller for a serial pattern detector (programmable pattern, target, bit budget).
// Optional build macro PAT_SEQ_MASK_EN adds cfg_mask_i don't-care bits to the compare. Rev 1.0
`default_nettype none

module pat_seq_ctrl #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8,
  parameter int BUD_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [PAT_W-1:0] cfg_pat_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic [CNT_W-1:0] cfg_target_i,
  input  logic [BUD_W-1:0] cfg_budget_i,
`ifdef PAT_SEQ_MASK_EN
  input  logic [PAT_W-1:0] cfg_mask_i,
`endif
  input  logic             din,
  input  logic             valid_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             pat_det_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic [BUD_W-1:0] bit_cnt_o,
  output logic [1:0]       status_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0]       ST_NONE   = 2'b00;
  localparam logic [1:0]       ST_TARGET = 2'b01;
  localparam logic [1:0]       ST_BUDGET = 2'b10;
  localparam logic [1:0]       ST_ABORT  = 2'b11;
  localparam logic [LEN_W-1:0] PAT_W_L   = LEN_W'(PAT_W);

  function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] l);
    logic [PAT_W-1:0] m;
    m = '0;
    for (int i = 0; i < PAT_W; i++) m[i] = (LEN_W'(i) < l);
    return m;
  endfunction

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] target_q;
  logic [BUD_W-1:0] budget_q;
`ifdef PAT_SEQ_MASK_EN
  logic [PAT_W-1:0] mask_q;
`endif
  // Only PAT_W-1 bits need storing: the compare always sees the freshly shifted bit.
  logic [PAT_W-2:0] hist;
  logic [LEN_W-1:0] fill;

  logic [PAT_W-1:0] hist_nxt;
  logic [PAT_W-1:0] care;
  logic [LEN_W-1:0] fill_nxt;
  logic [BUD_W-1:0] bit_nxt;
  logic [CNT_W-1:0] mcnt_nxt;
  logic             hit;
  logic             tgt_hit;
  logic             bud_hit;
  logic             len_ok;

  always_comb begin
    hist_nxt = {hist, din};
    fill_nxt = (fill == PAT_W_L) ? fill : fill + 1'b1;
    bit_nxt  = (&bit_cnt_o) ? bit_cnt_o : bit_cnt_o + 1'b1;
    mcnt_nxt = (&match_cnt_o) ? match_cnt_o : match_cnt_o + 1'b1;
`ifdef PAT_SEQ_MASK_EN
    care     = len_mask(len_q) & ~mask_q;
    len_ok   = (cfg_len_i != '0) && (cfg_len_i <= PAT_W_L) &&
               ((len_mask(cfg_len_i) & ~cfg_mask_i) != '0);
`else
    care     = len_mask(len_q);
    len_ok   = (cfg_len_i != '0) && (cfg_len_i <= PAT_W_L);
`endif
    hit      = (fill_nxt >= len_q) && (((hist_nxt ^ pat_q) & care) == '0);
    tgt_hit  = hit && (target_q != '0) && (mcnt_nxt == target_q);
    bud_hit  = (budget_q != '0) && (bit_nxt == budget_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      target_q    <= '0;
      budget_q    <= '0;
`ifdef PAT_SEQ_MASK_EN
      mask_q      <= '0;
`endif
      hist        <= '0;
      fill        <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      pat_det_o   <= 1'b0;
      match_cnt_o <= '0;
      bit_cnt_o   <= '0;
      status_o    <= ST_NONE;
    end else begin
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      pat_det_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (len_ok) begin
              pat_q    <= cfg_pat_i;
              len_q    <= cfg_len_i;
              target_q <= cfg_target_i;
              budget_q <= cfg_budget_i;
`ifdef PAT_SEQ_MASK_EN
              mask_q   <= cfg_mask_i;
`endif
              busy_o   <= 1'b1;
              state    <= ARM;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        ARM: begin
          hist        <= '0;
          fill        <= '0;
          match_cnt_o <= '0;
          bit_cnt_o   <= '0;
          status_o    <= ST_NONE;
          state       <= RUN;
        end
        RUN: begin
          if (abort_i) begin
            status_o <= ST_ABORT;
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            state    <= DONE;
          end else if (valid_i) begin
            hist      <= hist_nxt[PAT_W-2:0];
            fill      <= fill_nxt;
            bit_cnt_o <= bit_nxt;
            if (hit) begin
              pat_det_o   <= 1'b1;
              match_cnt_o <= mcnt_nxt;
            end
            if (tgt_hit || bud_hit) begin
              status_o <= tgt_hit ? ST_TARGET : ST_BUDGET;
              done_o   <= 1'b1;
              busy_o   <= 1'b0;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pat_seq_ctrl.sv
// tb_pat_seq_ctrl: directed self-checking bench for pat_seq_ctrl.
`default_nettype none

module tb_pat_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  cfg_pat = '0;
  logic [3:0]  cfg_len = '0;
  logic [7:0]  cfg_target = '0;
  logic [15:0] cfg_budget = '0;
`ifdef PAT_SEQ_MASK_EN
  logic [7:0]  cfg_mask = '0;
`endif
  logic        din = 1'b0;
  logic        valid = 1'b0;
  logic        busy, done, err, pat_det;
  logic [7:0]  match_cnt;
  logic [15:0] bit_cnt;
  logic [1:0]  status;

  int n_cmp  = 0;
  int n_fail = 0;

  pat_seq_ctrl #(.PAT_W(8), .LEN_W(4), .CNT_W(8), .BUD_W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .abort_i     (abort),
    .cfg_pat_i   (cfg_pat),
    .cfg_len_i   (cfg_len),
    .cfg_target_i(cfg_target),
    .cfg_budget_i(cfg_budget),
`ifdef PAT_SEQ_MASK_EN
    .cfg_mask_i  (cfg_mask),
`endif
    .din         (din),
    .valid_i     (valid),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .pat_det_o   (pat_det),
    .match_cnt_o (match_cnt),
    .bit_cnt_o   (bit_cnt),
    .status_o    (status)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cfg(input logic [7:0] p, input logic [3:0] l,
                           input logic [7:0] t, input logic [15:0] b);
    cfg_pat = p; cfg_len = l; cfg_target = t; cfg_budget = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arm_busy", busy, 1);
    chk("arm_err", err, 0);
    tick();
  endtask

  task automatic send_bit(input logic b);
    din = b; valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  // Stream 1,1,0,1,1,0,1 against 1101: hits after bits 4 and 7, target 2 on bit 7.
  task automatic run_overlap(input int gap);
    logic [6:0] bits = 7'b1101101;
    logic [6:0] pul  = 7'b0001001;
    start_cfg(8'b0000_1101, 4'd4, 8'd2, 16'd0);
    for (int i = 6; i >= 0; i--) begin
      send_bit(bits[i]);
      chk("ovl_det", pat_det, pul[i]);
      chk("ovl_done", done, (i == 0));
      if (i != 0) begin
        for (int g = 0; g < gap; g++) begin
          din = ~din;
          tick();
          chk("gap_det", pat_det, 0);
          chk("gap_busy", busy, 1);
        end
      end
    end
    chk("ovl_busy", busy, 0);
    chk("ovl_status", status, 2'b01);
    chk("ovl_mcnt", match_cnt, 2);
    chk("ovl_bcnt", bit_cnt, 7);
    tick();
    chk("ovl_done_clr", done, 0);
    chk("ovl_mcnt_hold", match_cnt, 2);
    chk("ovl_status_hold", status, 2'b01);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_det", pat_det, 0);
    chk("rst_mcnt", match_cnt, 0);
    chk("rst_bcnt", bit_cnt, 0);
    chk("rst_status", status, 0);
    rst = 1'b0;
    tick();

    // Overlapping matches, continuous valid
    run_overlap(0);

    // Budget exhaustion: 1,0,1,1,1 never forms 1111
    start_cfg(8'b0000_1111, 4'd4, 8'd1, 16'd5);
    send_bit(1'b1); chk("bud_done1", done, 0);
    send_bit(1'b0); chk("bud_done2", done, 0);
    send_bit(1'b1); chk("bud_done3", done, 0);
    send_bit(1'b1); chk("bud_det4", pat_det, 0);
    send_bit(1'b1);
    chk("bud_det5", pat_det, 0);
    chk("bud_done5", done, 1);
    chk("bud_status", status, 2'b10);
    chk("bud_bcnt", bit_cnt, 5);
    chk("bud_mcnt", match_cnt, 0);
    tick();

    // Valid gaps with toggling din
    run_overlap(2);

    // Target and budget on the same bit
    start_cfg(8'b0000_0001, 4'd1, 8'd3, 16'd3);
    send_bit(1'b1); chk("sim_det1", pat_det, 1); chk("sim_done1", done, 0);
    send_bit(1'b1); chk("sim_det2", pat_det, 1); chk("sim_done2", done, 0);
    send_bit(1'b1); chk("sim_det3", pat_det, 1); chk("sim_done3", done, 1);
    chk("sim_status", status, 2'b01);
    chk("sim_mcnt", match_cnt, 3);
    chk("sim_bcnt", bit_cnt, 3);
    tick();

    // Abort after 3 bits, with ignored starts while busy
    start_cfg(8'b0000_1111, 4'd4, 8'd0, 16'd0);
    send_bit(1'b1);
    cfg_len = 4'd0; start = 1'b1;
    tick();
    chk("busy_start_err", err, 0);
    cfg_pat = 8'h00; cfg_len = 4'd1;
    tick();
    start = 1'b0;
    chk("busy_start_busy", busy, 1);
    chk("busy_start_bcnt", bit_cnt, 1);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("abt_pre_bcnt", bit_cnt, 3);
    abort = 1'b1; din = 1'b1; valid = 1'b1;
    tick();
    abort = 1'b0; valid = 1'b0;
    chk("abt_done", done, 1);
    chk("abt_busy", busy, 0);
    chk("abt_status", status, 2'b11);
    chk("abt_bcnt", bit_cnt, 3);
    chk("abt_det", pat_det, 0);
    tick();
    chk("abt_done_clr", done, 0);

    // Illegal lengths
    cfg_len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_err", err, 1);
    chk("len0_busy", busy, 0);
    tick();
    chk("len0_err_clr", err, 0);
    chk("len0_busy2", busy, 0);
    cfg_len = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len9_err", err, 1);
    chk("len9_busy", busy, 0);
    tick();

    // Async reset mid-RUN
    start_cfg(8'b0000_1101, 4'd4, 8'd2, 16'd0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    chk("ar_pre_bcnt", bit_cnt, 3);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_bcnt", bit_cnt, 0);
    chk("ar_mcnt", match_cnt, 0);
    chk("ar_status", status, 0);
    chk("ar_done", done, 0);
    #1 rst = 1'b0;
    tick();
    chk("ar_done2", done, 0);
    chk("ar_busy2", busy, 0);
    run_overlap(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
